// File: rtl/rv_isa_pkg.sv
// RV32I field constants, encoder command codes and word-building helpers
// shared by the U-type encoder and its output FIFO.
package rv_isa_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI   = 3'b000;

  typedef enum logic [1:0] {
    CMD_LUI   = 2'b00,
    CMD_AUIPC = 2'b01,
    CMD_LI    = 2'b10,
    CMD_ILL   = 2'b11
  } cmd_op_e;

  // FIFO entry: {last, word}
  localparam int ENTRY_W = 33;

  function automatic logic [31:0] enc_u(input logic [19:0] imm20,
                                        input logic [4:0]  rd,
                                        input logic [6:0]  opc);
    return {imm20, rd, opc};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] lo12,
                                           input logic [4:0]  rs1,
                                           input logic [4:0]  rd);
    return {lo12, rs1, F3_ADDI, rd, OPC_OPIMM};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of {last, word}; head is presented directly from storage
// so a pushed entry is visible the cycle after the push. Head reads 0 when empty.
module inst_fifo
  import rv_isa_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr_reg, rd_ptr_reg;
  logic               do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
          mem[gi] <= push_data;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/inst_u_enc.sv
// U-type instruction encoder: LUI/AUIPC/LI commands in, RV32I words out via FIFO.
// Optional macro U_ENC_STATS_EN adds the inst_count pop counter port.
module inst_u_enc
  import rv_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_rd,
  input  logic [31:0]      cmd_imm,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_word,
  output logic             inst_last,
  output logic             err,
  output logic             busy
`ifdef U_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] inst_count
`endif
);

  typedef enum logic {IDLE, SECOND} state_e;

  state_e             state_reg, state_next;
  logic               err_reg, err_next;
  logic [4:0]         rd_reg, rd_next;
  logic [11:0]        lo_reg, lo_next;
  logic               push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty;
  logic               cmd_fire;
  logic [11:0]        li_lo;
  logic [19:0]        li_hi;

  // (imm + 0x800) >> 12 reduces to the upper 20 bits plus the rounding bit imm[11].
  assign li_lo = cmd_imm[11:0];
  assign li_hi = cmd_imm[31:12] + {19'd0, cmd_imm[11]};

  assign cmd_ready  = (state_reg == IDLE) && !fifo_full;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign inst_valid = !fifo_empty;
  assign inst_word  = head[31:0];
  assign inst_last  = head[32];
  assign err        = err_reg;
  assign busy       = (state_reg == SECOND) || !fifo_empty;

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    rd_next    = rd_reg;
    lo_next    = lo_reg;
    push       = 1'b0;
    push_data  = '0;
    unique case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            CMD_LUI: begin
              push      = 1'b1;
              push_data = {1'b1, enc_u(cmd_imm[31:12], cmd_rd, OPC_LUI)};
            end
            CMD_AUIPC: begin
              push      = 1'b1;
              push_data = {1'b1, enc_u(cmd_imm[31:12], cmd_rd, OPC_AUIPC)};
            end
            CMD_LI: begin
              push = 1'b1;
              if (li_hi == 20'd0) begin
                push_data = {1'b1, enc_addi(li_lo, 5'd0, cmd_rd)};
              end else if (li_lo == 12'd0) begin
                push_data = {1'b1, enc_u(li_hi, cmd_rd, OPC_LUI)};
              end else begin
                push_data  = {1'b0, enc_u(li_hi, cmd_rd, OPC_LUI)};
                rd_next    = cmd_rd;
                lo_next    = li_lo;
                state_next = SECOND;
              end
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      SECOND: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_data  = {1'b1, enc_addi(lo_reg, rd_reg, rd_reg)};
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
      rd_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      rd_reg    <= rd_next;
      lo_reg    <= lo_next;
    end
  end

  inst_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(push_data),
    .pop      (inst_ready),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef U_ENC_STATS_EN
  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n)
      count_reg <= '0;
    else if (inst_valid && inst_ready)
      count_reg <= count_reg + 1'b1;
  end

  assign inst_count = count_reg;
`endif

endmodule

// File: tb/tb_inst_u_enc.sv
// Bench for inst_u_enc: directed cases with known encodings plus randomized
// traffic checked against an arithmetic reference model and an expected-word queue.
module tb_inst_u_enc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_rd;
  logic [31:0] cmd_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic        inst_last;
  logic        err;
  logic        busy;
`ifdef U_ENC_STATS_EN
  logic [15:0] inst_count;
`endif

  always #5 clk = ~clk;

  inst_u_enc #(
    .FIFO_DEPTH(4),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_imm   (cmd_imm),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_word (inst_word),
    .inst_last (inst_last),
    .err       (err),
    .busy      (busy)
`ifdef U_ENC_STATS_EN
    ,
    .inst_count(inst_count)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int pop_total = 0;

  logic [32:0] exp_q[$];
  logic [32:0] popped[$];
  logic        err_exp = 1'b0;
  logic        hold_v = 1'b0;
  logic [32:0] hold_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: what each accepted command must eventually produce.
  function automatic void model_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] imm);
    int unsigned lo, hi, r;
    r  = 32'(rd);
    lo = imm & 32'h0000_0FFF;
    hi = (imm + 32'h800) >> 12;
    case (op)
      2'd0: exp_q.push_back({1'b1, (imm & 32'hFFFF_F000) | (r << 7) | 32'h37});
      2'd1: exp_q.push_back({1'b1, (imm & 32'hFFFF_F000) | (r << 7) | 32'h17});
      2'd2: begin
        if (hi == 0)
          exp_q.push_back({1'b1, (lo << 20) | (r << 7) | 32'h13});
        else if (lo == 0)
          exp_q.push_back({1'b1, (hi << 12) | (r << 7) | 32'h37});
        else begin
          exp_q.push_back({1'b0, (hi << 12) | (r << 7) | 32'h37});
          exp_q.push_back({1'b1, (lo << 20) | (r << 15) | (r << 7) | 32'h13});
        end
      end
      default: err_exp = 1'b1;
    endcase
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees this cycle's handshakes.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset_n) begin
      exp_q.delete();
      err_exp = 1'b0;
      hold_v  = 1'b0;
    end else begin
      check("err", 32'(err), 32'(err_exp));
      if (hold_v && inst_valid) begin
        check("hold_word", inst_word, hold_e[31:0]);
        check("hold_last", 32'(inst_last), 32'(hold_e[32]));
      end
      if (inst_valid && inst_ready) begin
        check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word", inst_word, e[31:0]);
          check("last", 32'(inst_last), 32'(e[32]));
        end
        popped.push_back({inst_last, inst_word});
        pop_total++;
      end
      hold_v  = inst_valid && !inst_ready;
      hold_e  = {inst_last, inst_word};
      err_exp = 1'b0;
      if (cmd_valid && cmd_ready) model_cmd(cmd_op, cmd_rd, cmd_imm);
    end
  end

  // Entered and left at posedge+1.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] imm);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_imm   = imm;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain", 32'(done), 32'd1);
  endtask

  task automatic expect_words(input string tag, input int n, input logic [32:0] e0, input logic [32:0] e1);
    check({tag, "_count"}, 32'(popped.size()), 32'(n));
    if (n > 0 && popped.size() > 0) begin
      check({tag, "_w0"}, popped[0][31:0], e0[31:0]);
      check({tag, "_l0"}, 32'(popped[0][32]), 32'(e0[32]));
    end
    if (n > 1 && popped.size() > 1) begin
      check({tag, "_w1"}, popped[1][31:0], e1[31:0]);
      check({tag, "_l1"}, 32'(popped[1][32]), 32'(e1[32]));
    end
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [4:0] rd, input logic [31:0] imm,
                        input int n, input logic [32:0] e0, input logic [32:0] e1);
    popped.delete();
    send_cmd(op, rd, imm);
    wait_drain();
    expect_words(tag, n, e0, e1);
    $display("txn %s op=%0d rd=%0d imm=0x%08h words=%0d", tag, op, rd, imm, popped.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit acc;
    logic [31:0] r;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_rd     = 5'd0;
    cmd_imm    = 32'd0;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_word", inst_word, 32'd0);
    check("rst_inst_last", 32'(inst_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef U_ENC_STATS_EN
    check("rst_inst_count", 32'(inst_count), 32'd0);
`endif
    @(posedge clk);
    #1;

    single("lui", 2'd0, 5'd5, 32'h1234_5000, 1, {1'b1, 32'h1234_52B7}, '0);
    single("auipc", 2'd1, 5'd1, 32'hFFFF_F000, 1, {1'b1, 32'hFFFF_F097}, '0);

    popped.delete();
    send_cmd(2'd2, 5'd10, 32'h1234_5678);
    @(negedge clk);
    check("li_second_ready", 32'(cmd_ready), 32'd0);
    check("li_second_busy", 32'(busy), 32'd1);
    wait_drain();
    expect_words("li_pair", 2, {1'b0, 32'h1234_5537}, {1'b1, 32'h6785_0513});
    $display("txn li_pair rd=10 imm=0x12345678 words=%0d", popped.size());

    single("li_wrap", 2'd2, 5'd10, 32'hFFFF_F800, 1, {1'b1, 32'h8000_0513}, '0);
    single("li_luionly", 2'd2, 5'd3, 32'h0000_1000, 1, {1'b1, 32'h0000_11B7}, '0);
    single("li_small", 2'd2, 5'd0, 32'h0000_07FF, 1, {1'b1, 32'h7FF0_0013}, '0);

    // Illegal op: exactly one err pulse, nothing emitted.
    popped.delete();
    send_cmd(2'd3, 5'd7, 32'hDEAD_BEEF);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(err);
    end
    wait_drain();
    check("ill_err_cycles", 32'(cnt), 32'd1);
    check("ill_no_words", 32'(popped.size()), 32'd0);
    $display("txn illegal err_cycles=%0d", cnt);

    // Backpressure: four LUIs fill the FIFO, the fifth waits for a pop.
    popped.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(2'd0, 5'(i + 1), 32'(i + 1) << 12);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_rd    = 5'd5;
    cmd_imm   = 32'h0000_5000;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(cmd_ready);
    end
    check("bp_ready_low", 32'(cnt), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("bp_fifth_accept", 32'(acc), 32'd1);
    wait_drain();
    check("bp_count", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check("bp_order", popped[i][31:0], ((32'(i) + 1) << 12) | ((32'(i) + 1) << 7) | 32'h37);
    $display("txn backpressure words=%0d", popped.size());

    // Reset while stuck in SECOND (FIFO full) must drop the pending ADDI.
    popped.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(2'd0, 5'd2, 32'h0000_3000);
    send_cmd(2'd2, 5'd10, 32'h1234_5678);
    @(negedge clk);
    check("sec_busy", 32'(busy), 32'd1);
    check("sec_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("sec_rst_valid", 32'(inst_valid), 32'd0);
    check("sec_rst_busy", 32'(busy), 32'd0);
    inst_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("sec_rst_no_words", 32'(popped.size()), 32'd0);
    $display("txn reset_in_second words=%0d", popped.size());
    pop_total = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      cmd_valid  = 1'($urandom % 2);
      cmd_op     = 2'($urandom % 4);
      cmd_rd     = 5'($urandom);
      r          = $urandom;
      case ($urandom % 5)
        0: cmd_imm = r & 32'hFFFF_F000;
        1: cmd_imm = r & 32'h0000_0FFF;
        2: cmd_imm = 32'hFFFF_F800 | (r & 32'h7FF);
        default: cmd_imm = r;
      endcase
      inst_ready = (($urandom % 4) != 0);
      if (cmd_valid && cmd_ready)
        $display("txn rand op=%0d rd=%0d imm=0x%08h", cmd_op, cmd_rd, cmd_imm);
      @(posedge clk);
      #1;
    end
    cmd_valid  = 1'b0;
    inst_ready = 1'b1;
    wait_drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
`ifdef U_ENC_STATS_EN
    check("final_count", 32'(inst_count), 32'(16'(pop_total)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`ifdef U_ENC_STATS_EN
  // inst_count is not cleared by the bench's mid-run reset bookkeeping; track it separately.
  int pops_since_reset = 0;
  always @(posedge clk) begin
    if (!reset_n) pops_since_reset <= 0;
    else if (inst_valid && inst_ready) pops_since_reset <= pops_since_reset + 1;
  end
`endif

endmodule
